// File: rtl/cfg_txn_sequencer.sv
// Host-side transaction FIFO feeding the counter cfg bus.
// Each entry is driven with a fixed enable width followed by an idle gap.
module cfg_txn_sequencer #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 10,
  parameter int DEPTH         = 4,
  parameter int ENABLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic              clk_sig,
  input  logic              rst_n_sig,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_rd_wr_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  output logic              cfg_enable_sig,
  output logic              cfg_rd_wr_sig,
  output logic [ADDR_W-1:0] cfg_addr_sig,
  output logic [DATA_W-1:0] cfg_wdata_sig,
  input  logic [DATA_W-1:0] cfg_rdata_sig,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CMAX = (ENABLE_CYCLES > GAP_CYCLES) ?
                        ENABLE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef struct packed {
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  txn_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  state_t        state;
  logic [CW-1:0] cnt;

  logic full;
  logic push;
  logic pop;
  txn_t head;

  assign full       = (count == (PW+1)'(DEPTH));
  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;
  assign head       = mem[rd_ptr];
  assign busy_o     = (state != IDLE) || (count != '0);

  // Pop happens exactly when the FSM launches a new transaction.
  assign pop = (count != '0) &&
               ((state == IDLE) ||
                ((state == GAP) && (cnt == '0)));

  always_ff @(posedge clk_sig) begin
    if (push) begin
      mem[wr_ptr] <= {in_rd_wr_i, in_addr_i, in_wdata_i};
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state          <= IDLE;
      cnt            <= '0;
      cfg_enable_sig <= 1'b0;
      cfg_rd_wr_sig  <= 1'b0;
      cfg_addr_sig   <= '0;
      cfg_wdata_sig  <= '0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            cfg_enable_sig <= 1'b1;
            cfg_rd_wr_sig  <= head.rd_wr;
            cfg_addr_sig   <= head.addr;
            cfg_wdata_sig  <= head.wdata;
            cnt            <= CW'(ENABLE_CYCLES - 1);
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            cfg_enable_sig <= 1'b0;
            if (cfg_rd_wr_sig) begin
              rd_data_o  <= cfg_rdata_sig;
              rd_valid_o <= 1'b1;
            end
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (pop) begin
              cfg_enable_sig <= 1'b1;
              cfg_rd_wr_sig  <= head.rd_wr;
              cfg_addr_sig   <= head.addr;
              cfg_wdata_sig  <= head.wdata;
              cnt            <= CW'(ENABLE_CYCLES - 1);
              state          <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_txn_sequencer.sv
// Directed bench for cfg_txn_sequencer with a cfg-bus scoreboard.
// A negedge monitor pops expected transactions and read data.
module tb_cfg_txn_sequencer;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 10;
  localparam int EN_CYC = 2;

  typedef struct packed {
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_rd_wr;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              en;
  logic              cfg_rd_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [DATA_W-1:0] cfg_rdata;
  logic              rdv;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  cfg_txn_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH(4),
    .ENABLE_CYCLES(EN_CYC),
    .GAP_CYCLES(1)
  ) dut (
    .clk_sig(clk),
    .rst_n_sig(rst_n),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_rd_wr_i(in_rd_wr),
    .in_addr_i(in_addr),
    .in_wdata_i(in_wdata),
    .cfg_enable_sig(en),
    .cfg_rd_wr_sig(cfg_rd_wr),
    .cfg_addr_sig(cfg_addr),
    .cfg_wdata_sig(cfg_wdata),
    .cfg_rdata_sig(cfg_rdata),
    .rd_valid_o(rdv),
    .rd_data_o(rd_data),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  txn_t              exp_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   rise_cyc   = 0;
  int   last_spacing = 0;
  int   n_rises    = 0;
  int   en_len     = 0;
  int   stalls     = 0;
  int   rises_snap = 0;
  logic prev_en    = 1'b0;
  logic prev_rdv   = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic note_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed unexpected event expected none", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rd,
                      input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_rd_wr = rd;
    in_addr  = a;
    in_wdata = d;
    while (!in_ready && guard < 50) begin
      stalls++;
      guard++;
      step();
    end
    if (!in_ready) note_fail("push_timeout");
    @(posedge clk);
    exp_q.push_back({rd, a, d});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin
      g++;
      step();
    end
    if (busy) note_fail("idle_timeout");
  endtask

  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_rdv = 1'b0;
      en_len   = 0;
    end else begin
      if (en && !prev_en) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_txn");
        end else begin
          t = exp_q.pop_front();
          chk("bus_rd_wr", cfg_rd_wr, t.rd_wr);
          chk("bus_addr", cfg_addr, t.addr);
          chk("bus_wdata", cfg_wdata, t.wdata);
        end
        if (n_rises > 0) last_spacing = cyc - rise_cyc;
        rise_cyc = cyc;
        n_rises++;
        en_len = 0;
      end
      if (en) en_len++;
      if (!en && prev_en) chk("en_width", en_len, EN_CYC);
      if (rdv) begin
        chk("rdv_at_fall", {prev_en, en}, 2'b10);
        chk("rdv_one_cycle", prev_rdv, 1'b0);
        if (rd_q.size() == 0) note_fail("unexpected_rdv");
        else chk("rd_data", rd_data, rd_q.pop_front());
      end
      prev_en  = en;
      prev_rdv = rdv;
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_rd_wr  = 1'b0;
    in_addr   = '0;
    in_wdata  = '0;
    cfg_rdata = '0;
    repeat (3) step();
    chk("rst_en", en, 1'b0);
    chk("rst_rdv", rdv, 1'b0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_addr", cfg_addr, 0);
    #2 rst_n = 1'b1;
    step();

    // single write: latency, width, busy tail
    push(1'b0, 3'h0, 10'h001);
    chk("t1_not_yet", en, 1'b0);
    step();
    chk("t1_en", en, 1'b1);
    chk("t1_rd_wr", cfg_rd_wr, 1'b0);
    chk("t1_addr", cfg_addr, 3'h0);
    chk("t1_wdata", cfg_wdata, 10'h001);
    step();
    chk("t1_en_hold", en, 1'b1);
    step();
    chk("t1_en_low", en, 1'b0);
    chk("t1_busy_gap", busy, 1'b1);
    chk("t1_no_rdv", rdv, 1'b0);
    step();
    chk("t1_busy_done", busy, 1'b0);
    chk("t1_hold_wdata", cfg_wdata, 10'h001);

    // back-to-back writes
    push(1'b0, 3'h0, 10'h001);
    push(1'b0, 3'h3, 10'h003);
    wait_idle();
    chk("t2_spacing", last_spacing, 3);
    chk("t2_drained", exp_q.size(), 0);

    // read with capture
    cfg_rdata = 10'h2A5;
    push(1'b1, 3'h5, 10'h155);
    rd_q.push_back(10'h2A5);
    step();
    chk("t3_en", en, 1'b1);
    chk("t3_rd_wr", cfg_rd_wr, 1'b1);
    chk("t3_addr", cfg_addr, 3'h5);
    step();
    step();
    chk("t3_en_low", en, 1'b0);
    chk("t3_rdv", rdv, 1'b1);
    chk("t3_rd_data", rd_data, 10'h2A5);
    step();
    chk("t3_rdv_gone", rdv, 1'b0);
    chk("t3_rd_hold", rd_data, 10'h2A5);
    cfg_rdata = '0;
    wait_idle();
    chk("t3_rd_q", rd_q.size(), 0);

    // fill past full; one push refused at a pop edge
    stalls     = 0;
    rises_snap = n_rises;
    for (int i = 0; i < 7; i++) begin
      push(1'b0, 3'(i), 10'(16 + i));
      if (i == 5) chk("t4_full_ready", in_ready, 1'b0);
    end
    chk("t5_stalls", stalls, 2);
    wait_idle();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_count", n_rises - rises_snap, 7);

    // reset during an enable with entries queued
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 3'(i), 10'(32 + i));
    end
    chk("t6_en_before", en, 1'b1);
    chk("t6_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_en_drop", en, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_ready_rst", in_ready, 1'b1);
    exp_q.delete();
    rises_snap = n_rises;
    step();
    step();
    #2 rst_n = 1'b1;
    repeat (20) step();
    chk("t6_no_pulses", n_rises - rises_snap, 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_en", en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
